sram_frame_reader: RTL and testbench
====================================

SRAM_FRAME_READER -- requirements
Module: sram_frame_reader

Interface
REQ-001 Parameter BASE_ADDR, default 20'h00000, first SRAM word address of the frame.
REQ-002 Parameter FRAME_WORDS, default 76800, number of 16-bit words per frame (1..1048576).
REQ-003 Parameter READ_WAIT, default 1, extra wait cycles between address valid and data capture (0..15).
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 frame_start  input  1  single-cycle pulse that starts one frame read.
REQ-007 abort  input  1  synchronous stop: terminates the frame and flushes buffered words.
REQ-008 sram_addr  output  20  SRAM word address, registered.
REQ-009 sram_dq  inout  16  SRAM data bus; this block never drives it (constant high-Z).
REQ-010 ce_n, ub_n, lb_n  output  1 each  held 0 (chip and both bytes always enabled).
REQ-011 we_n  output  1  held 1 (never writes).
REQ-012 oe_n  output  1  registered output enable, active-low.
REQ-013 pix_data  output  16  head-of-FIFO word.
REQ-014 pix_valid / pix_ready  output / input  1 each  stream handshake; transfer when both are 1 on a rising edge.
REQ-015 pix_sof / pix_eof  output  1 each  qualify pix_data as first / last word of the frame, valid only with pix_valid.
REQ-016 busy  output  1  high from accepted frame_start until last word leaves the FIFO.
REQ-017 frame_done  output  1  one-cycle pulse on the cycle the eof word transfers.

Function
REQ-018 FSM states: IDLE, READ, DRAIN; no other states.
REQ-019 IDLE: on frame_start=1, load sram_addr=BASE_ADDR, words_left=FRAME_WORDS, oe_n=0, wait counter=READ_WAIT, go to READ.
REQ-020 READ: wait counter decrements each cycle while nonzero; when zero and FIFO occupancy < 4, capture sram_dq into FIFO on that edge.
REQ-021 One read is in flight at a time; throughput is one word per READ_WAIT+1 cycles when the FIFO is not full.
REQ-022 If the FIFO is full when the counter reaches zero, sram_addr and oe_n hold, and capture occurs on the first edge with space.
REQ-023 On capture, sram_addr increments by 1 (wraps 20'hFFFFF->20'h00000), words_left decrements, and the counter reloads to READ_WAIT.
REQ-024 The first captured word is tagged sof=1; the word captured when words_left=1 is tagged eof=1; FRAME_WORDS=1 tags both on one word.
REQ-025 After the eof capture: oe_n=1, go to DRAIN.
REQ-026 DRAIN: go to IDLE on the edge the eof word transfers (pix_valid & pix_ready & pix_eof).
REQ-027 FIFO: 4 entries x 18 bits (data, sof, eof), first-word-fall-through; pix_valid = not empty.
REQ-028 A simultaneous capture and pop while full is allowed only through the full-stall rule: a push never occurs when occupancy is 4 at the start of the cycle.
REQ-029 A simultaneous push and pop leaves occupancy unchanged.
REQ-030 frame_start while busy is ignored.
REQ-031 abort=1 in any state: next edge goes to IDLE, FIFO is emptied, oe_n=1, and no frame_done pulse.
REQ-032 abort has priority over frame_start and capture in the same cycle.
REQ-033 pix_data, pix_sof, and pix_eof are stable while pix_valid=1 and pix_ready=0.

Reset
REQ-034 While rst=0 the block holds: state=IDLE, FIFO empty, sram_addr=20'h00000, oe_n=1, we_n=1, ce_n=ub_n=lb_n=0, pix_valid=0, busy=0, frame_done=0.
REQ-035 Reset assertion mid-frame takes effect immediately (asynchronously) and discards all buffered data.
REQ-036 After reset release, the first frame_start is honoured on the next rising edge.

Verification
REQ-037 FRAME_WORDS=4, BASE_ADDR=0x00010, READ_WAIT=1, SRAM model returns addr[15:0]^16'hA5A5, pix_ready=1 -> words 0xA5B5, 0xA5B4, 0xA5B7, 0xA5B6 at 2-cycle spacing; sof on the first, eof and frame_done on the fourth; busy is then low.
REQ-038 Same setup with pix_ready=0 for 20 cycles -> exactly 4 words are buffered, sram_addr holds at 0x00013, and no data is lost after release.
REQ-039 BASE_ADDR=0xFFFFE, FRAME_WORDS=3 -> addresses 0xFFFFE, 0xFFFFF, 0x00000.
REQ-040 abort asserted after the 2nd capture -> next cycle pix_valid=0, oe_n=1, state IDLE, no frame_done; the following frame_start restarts at BASE_ADDR.
REQ-041 frame_start pulsed again mid-frame -> ignored; word count stays FRAME_WORDS.
REQ-042 rst=0 mid-frame -> all outputs at their REQ-034 values without waiting for a clock edge; sram_dq stays high-Z throughout.

Source files
------------

// File: rtl/sram_frame_reader_if.sv
// Control, SRAM address/strobe and pixel-stream signals of the SRAM frame reader.
interface sram_frame_reader_if;
  logic        frame_start;
  logic        abort;
  logic [19:0] sram_addr;
  logic        ce_n;
  logic        ub_n;
  logic        lb_n;
  logic        we_n;
  logic        oe_n;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eof;
  logic        busy;
  logic        frame_done;

  modport master (
    input  frame_start, abort, pix_ready,
    output sram_addr, ce_n, ub_n, lb_n, we_n, oe_n,
    output pix_data, pix_valid, pix_sof, pix_eof, busy, frame_done
  );

  modport slave (
    output frame_start, abort, pix_ready,
    input  sram_addr, ce_n, ub_n, lb_n, we_n, oe_n,
    input  pix_data, pix_valid, pix_sof, pix_eof, busy, frame_done
  );
endinterface

// File: rtl/sram_frame_reader.sv
// Reads one frame of 16-bit words from an asynchronous SRAM into a 4-deep
// first-word-fall-through FIFO and streams it out with sof/eof tags.
module sram_frame_reader #(
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter int unsigned FRAME_WORDS = 76800,
  parameter int unsigned READ_WAIT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  sram_frame_reader_if.master        bus,
  inout  wire [15:0]                 sram_dq
);

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned LEFT_W = 21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eof;
  } fifo_word_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                r_oe_n, w_oe_n_nxt;
  logic [WAIT_W-1:0]   r_wait, w_wait_nxt;
  logic [LEFT_W-1:0]   r_left, w_left_nxt;

  fifo_word_t          r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic                w_valid;
  fifo_word_t          w_head;
  fifo_word_t          w_capture;

  // The data bus is only ever sampled.
  assign sram_dq = {DATA_W{1'bz}};

  assign w_valid = (r_count != '0);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_flush = bus.abort;
  assign w_pop   = w_valid & bus.pix_ready & ~bus.abort;

  assign w_capture.data = sram_dq;
  assign w_capture.sof  = (r_left == LEFT_W'(FRAME_WORDS));
  assign w_capture.eof  = (r_left == LEFT_W'(1));

  // Register state and read-side datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_oe_n  <= 1'b1;
      r_wait  <= '0;
      r_left  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_oe_n  <= w_oe_n_nxt;
      r_wait  <= w_wait_nxt;
      r_left  <= w_left_nxt;
    end
  end

  // Next-state logic: abort wins over everything, capture only with FIFO space.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_oe_n_nxt  = r_oe_n;
    w_wait_nxt  = r_wait;
    w_left_nxt  = r_left;
    w_push      = 1'b0;

    if (bus.abort) begin
      w_state_nxt = IDLE;
      w_oe_n_nxt  = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.frame_start) begin
            w_state_nxt = READ;
            w_addr_nxt  = BASE_ADDR;
            w_left_nxt  = LEFT_W'(FRAME_WORDS);
            w_oe_n_nxt  = 1'b0;
            w_wait_nxt  = WAIT_W'(READ_WAIT);
          end
        end
        READ: begin
          if (r_wait != '0) begin
            w_wait_nxt = r_wait - WAIT_W'(1);
          end else if (r_count < CNT_W'(DEPTH)) begin
            w_push     = 1'b1;
            w_left_nxt = r_left - LEFT_W'(1);
            w_wait_nxt = WAIT_W'(READ_WAIT);
            if (r_left == LEFT_W'(1)) begin
              // Last word: the address stays on the final word read.
              w_oe_n_nxt  = 1'b1;
              w_state_nxt = DRAIN;
            end else begin
              w_addr_nxt = r_addr + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (w_pop && w_head.eof) begin
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the occupancy says empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_capture;
    end
  end

  // FIFO pointers and occupancy; abort empties the FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign bus.sram_addr  = r_addr;
  assign bus.oe_n       = r_oe_n;
  assign bus.ce_n       = 1'b0;
  assign bus.ub_n       = 1'b0;
  assign bus.lb_n       = 1'b0;
  assign bus.we_n       = 1'b1;
  assign bus.pix_data   = w_head.data;
  assign bus.pix_sof    = w_head.sof;
  assign bus.pix_eof    = w_head.eof;
  assign bus.pix_valid  = w_valid;
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_done = (r_state == DRAIN) & w_pop & w_head.eof;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Scoreboard bench for sram_frame_reader: two instances (normal and address-wrap).
module tb_sram_frame_reader;

  localparam logic [19:0] A_BASE  = 20'h00010;
  localparam int unsigned A_WORDS = 4;
  localparam logic [19:0] B_BASE  = 20'hFFFFE;
  localparam int unsigned B_WORDS = 3;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eof;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sram_frame_reader_if a_if();
  sram_frame_reader_if b_if();
  wire [15:0] dq_a;
  wire [15:0] dq_b;
  assign dq_a = a_if.sram_addr[15:0] ^ 16'hA5A5;
  assign dq_b = b_if.sram_addr[15:0] ^ 16'hA5A5;

  sram_frame_reader #(.BASE_ADDR(A_BASE), .FRAME_WORDS(A_WORDS), .READ_WAIT(1)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if), .sram_dq(dq_a));
  sram_frame_reader #(.BASE_ADDR(B_BASE), .FRAME_WORDS(B_WORDS), .READ_WAIT(0)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if), .sram_dq(dq_b));

  word_t exp_a[$];
  word_t exp_b[$];
  bit open_a = 1'b0;
  bit open_b = 1'b0;
  bit spacing_en = 1'b0;
  int last_a = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference frame: consecutive addresses modulo 2^20, data = addr ^ A5A5.
  function automatic void push_frame(input bit to_b);
    logic [19:0] base;
    logic [19:0] addr;
    int unsigned n;
    word_t w;
    base = to_b ? B_BASE : A_BASE;
    n    = to_b ? B_WORDS : A_WORDS;
    for (int unsigned i = 0; i < n; i++) begin
      addr   = base + 20'(i);
      w.data = addr[15:0] ^ 16'hA5A5;
      w.sof  = (i == 0);
      w.eof  = (i == n - 1);
      if (to_b) exp_b.push_back(w);
      else      exp_a.push_back(w);
    end
  endfunction

  // Monitor A: pops the scoreboard on every transfer, checks hold-stability.
  word_t prev_a;
  bit hold_a = 1'b0;
  always @(negedge clk) begin
    word_t e;
    if (rst) begin
      if (hold_a)
        check("a_stable", 32'({a_if.pix_valid, a_if.pix_data, a_if.pix_sof, a_if.pix_eof}),
              32'({1'b1, prev_a.data, prev_a.sof, prev_a.eof}));
      if (a_if.pix_valid && a_if.pix_ready && !a_if.abort) begin
        if (exp_a.size() == 0) begin
          check("a_unexpected_word", 32'(a_if.pix_valid), 32'd0);
        end else begin
          e = exp_a.pop_front();
          check("a_word", 32'({a_if.pix_data, a_if.pix_sof, a_if.pix_eof}),
                32'({e.data, e.sof, e.eof}));
          check("a_frame_done", 32'(a_if.frame_done), 32'(e.eof));
          if (spacing_en && !e.sof) check("a_spacing", 32'(cyc - last_a), 32'd2);
          last_a = cyc;
          if (e.eof) open_a = 1'b0;
        end
      end else if (a_if.frame_done) begin
        check("a_spurious_done", 32'(a_if.frame_done), 32'd0);
      end
      hold_a = a_if.pix_valid && !a_if.pix_ready && !a_if.abort;
      prev_a = {a_if.pix_data, a_if.pix_sof, a_if.pix_eof};
    end else begin
      hold_a = 1'b0;
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    word_t e;
    if (rst) begin
      if (b_if.pix_valid && b_if.pix_ready && !b_if.abort) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected_word", 32'(b_if.pix_valid), 32'd0);
        end else begin
          e = exp_b.pop_front();
          check("b_word", 32'({b_if.pix_data, b_if.pix_sof, b_if.pix_eof}),
                32'({e.data, e.sof, e.eof}));
          check("b_frame_done", 32'(b_if.frame_done), 32'(e.eof));
          if (e.eof) open_b = 1'b0;
        end
      end else if (b_if.frame_done) begin
        check("b_spurious_done", 32'(b_if.frame_done), 32'd0);
      end
    end
  end

  task automatic start_a();
    a_if.frame_start = 1'b1;
    if (!open_a) begin
      push_frame(1'b0);
      open_a = 1'b1;
    end
    @(posedge clk);
    #1 a_if.frame_start = 1'b0;
  endtask

  task automatic start_b();
    b_if.frame_start = 1'b1;
    if (!open_b) begin
      push_frame(1'b1);
      open_b = 1'b1;
    end
    @(posedge clk);
    #1 b_if.frame_start = 1'b0;
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 300 && open_a; i++) @(posedge clk);
    #1;
    if (open_a) begin
      check("a_timeout", 32'(a_if.busy), 32'd0);
      exp_a.delete();
      open_a = 1'b0;
    end
    check("a_busy_after_frame", 32'(a_if.busy), 32'd0);
    check("a_queue_empty", 32'(exp_a.size()), 32'd0);
  endtask

  task automatic wait_idle_b(input bit rand_ready);
    for (int i = 0; i < 300 && open_b; i++) begin
      if (rand_ready) b_if.pix_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    if (open_b) begin
      check("b_timeout", 32'(b_if.busy), 32'd0);
      exp_b.delete();
      open_b = 1'b0;
    end
    @(posedge clk);
    #1;
    check("b_busy_after_frame", 32'(b_if.busy), 32'd0);
  endtask

  task automatic do_abort_a();
    a_if.abort = 1'b1;
    @(posedge clk);
    #1 a_if.abort = 1'b0;
    exp_a.delete();
    open_a = 1'b0;
    check("a_abort_valid", 32'(a_if.pix_valid), 32'd0);
    check("a_abort_oe_n", 32'(a_if.oe_n), 32'd1);
    check("a_abort_busy", 32'(a_if.busy), 32'd0);
  endtask

  // Random frame on A: random backpressure, stray frame_start pulses, optional abort.
  task automatic run_a_random(input int abort_at);
    bit aborted;
    aborted = 1'b0;
    start_a();
    for (int i = 0; i < 400 && open_a && !aborted; i++) begin
      a_if.pix_ready = ($urandom_range(0, 3) != 0);
      if (i == abort_at) begin
        do_abort_a();
        aborted = 1'b1;
      end else begin
        a_if.frame_start = ($urandom_range(0, 9) == 0);
        @(posedge clk);
        #1 a_if.frame_start = 1'b0;
      end
    end
    a_if.pix_ready = 1'b1;
    wait_idle_a();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.frame_start = 1'b0; a_if.abort = 1'b0; a_if.pix_ready = 1'b0;
    b_if.frame_start = 1'b0; b_if.abort = 1'b0; b_if.pix_ready = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 32'(a_if.sram_addr), 32'd0);
    check("rst_oe_n", 32'(a_if.oe_n), 32'd1);
    check("rst_we_n", 32'(a_if.we_n), 32'd1);
    check("rst_strobes", 32'({a_if.ce_n, a_if.ub_n, a_if.lb_n}), 32'd0);
    check("rst_valid", 32'(a_if.pix_valid), 32'd0);
    check("rst_busy", 32'(a_if.busy), 32'd0);
    check("rst_done", 32'(a_if.frame_done), 32'd0);

    // First frame_start right after reset release is taken on the next edge.
    rst = 1'b1;
    a_if.pix_ready = 1'b1;
    spacing_en = 1'b1;
    start_a();
    check("a_busy_after_start", 32'(a_if.busy), 32'd1);
    check("a_oe_n_reading", 32'(a_if.oe_n), 32'd0);
    check("a_addr_base", 32'(a_if.sram_addr), 32'(A_BASE));
    wait_idle_a();
    spacing_en = 1'b0;

    // Stalled consumer: FIFO fills, address parks on the last word.
    a_if.pix_ready = 1'b0;
    start_a();
    repeat (20) @(posedge clk);
    #1;
    check("stall_addr", 32'(a_if.sram_addr), 32'h00013);
    check("stall_oe_n", 32'(a_if.oe_n), 32'd1);
    check("stall_valid", 32'(a_if.pix_valid), 32'd1);
    check("stall_head", 32'(a_if.pix_data), 32'hA5B5);
    check("stall_busy", 32'(a_if.busy), 32'd1);
    a_if.pix_ready = 1'b1;
    wait_idle_a();

    // Abort after the second capture, then restart from BASE_ADDR.
    a_if.pix_ready = 1'b0;
    start_a();
    for (int i = 0; i < 50 && a_if.sram_addr != 20'h00012; i++) begin
      @(posedge clk);
      #1;
    end
    check("abort_point_addr", 32'(a_if.sram_addr), 32'h00012);
    do_abort_a();
    a_if.pix_ready = 1'b1;
    start_a();
    wait_idle_a();

    // frame_start mid-frame is ignored.
    start_a();
    repeat (3) @(posedge clk);
    #1;
    start_a();
    wait_idle_a();
    repeat (4) @(posedge clk);
    #1;
    check("a_no_restart", 32'(a_if.busy), 32'd0);

    // Address wrap on instance B.
    b_if.pix_ready = 1'b1;
    start_b();
    wait_idle_b(1'b0);
    check("b_final_addr", 32'(b_if.sram_addr), 32'h00000);
    for (int k = 0; k < 3; k++) begin
      start_b();
      wait_idle_b(1'b1);
    end

    // Randomised frames on A.
    for (int k = 0; k < 8; k++) begin
      run_a_random(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1);
    end

    // Asynchronous reset mid-frame.
    a_if.pix_ready = 1'b0;
    start_a();
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_addr", 32'(a_if.sram_addr), 32'd0);
    check("arst_oe_n", 32'(a_if.oe_n), 32'd1);
    check("arst_valid", 32'(a_if.pix_valid), 32'd0);
    check("arst_busy", 32'(a_if.busy), 32'd0);
    check("arst_done", 32'(a_if.frame_done), 32'd0);
    check("arst_we_n", 32'(a_if.we_n), 32'd1);
    exp_a.delete();
    open_a = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    a_if.pix_ready = 1'b1;
    start_a();
    check("a_busy_after_rst", 32'(a_if.busy), 32'd1);
    wait_idle_a();

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
